// File: rtl/m_progloader_pkg.sv
// Shared types and defaults for the serial program loader.
// Holds the RX and loader state encodings plus the header sanity check.
package m_progloader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_MAX_WORDS    = 4096;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_HDR,
    L_LOAD,
    L_DONE,
    L_ERR
  } ld_state_t;

  // A word count of zero or larger than the memory cannot be loaded.
  function automatic logic hdr_bad(input logic [31:0] n, input logic [31:0] max_words);
    return (n == 32'd0) || (n > max_words);
  endfunction

endpackage

// File: rtl/m_progloader_if.sv
// Memory write port driven by the loader into the instruction memory.
interface m_progloader_if;
  logic [11:0] addr;
  logic        we;
  logic [31:0] din;

  modport master (output addr, we, din);
  modport slave  (input  addr, we, din);
endinterface

// File: rtl/m_progloader_uartrx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling RX FSM,
// one-cycle byte-valid strobe and a sticky framing-error flag.
module m_uartrx
  import m_progloader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] r_data,
  output logic       r_valid,
  output logic       r_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx;

  assign rx      = sync_q[1];
  assign r_data  = shift_q;
  assign r_valid = valid_q;
  assign r_ferr  = ferr_q;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], w_rxd};
    prev_d  = rx;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the line half a bit in so short glitches are rejected.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx) valid_d = 1'b1;
          else    ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/m_progloader.sv
// Serial program loader: assembles UART bytes MSB-first into 32-bit words,
// takes the first word as a count and writes the rest to memory from word 0.
module m_progloader
  import m_progloader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MAX_WORDS    = DEF_MAX_WORDS
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_rxd,
  m_progloader_if.master         mem,
  output logic                   r_done,
  output logic                   r_err,
  output logic                   r_ferr,
  output logic [12:0]            r_cnt
);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;

  ld_state_t   state_q, state_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  nb_q, nb_d;
  logic [12:0] n_q, n_d;
  logic [12:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] word_full;
  logic        word_ready;

  m_uartrx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_rxd   (w_rxd),
    .r_data  (rx_data),
    .r_valid (rx_valid),
    .r_ferr  (rx_ferr)
  );

  assign word_full  = {word_q, rx_data};
  assign word_ready = rx_valid && (nb_q == 2'd3);

  assign mem.addr = addr_q;
  assign mem.we   = we_q;
  assign mem.din  = din_q;
  assign r_done   = done_q;
  assign r_err    = err_q;
  assign r_ferr   = rx_ferr;
  assign r_cnt    = cnt_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    nb_d    = nb_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
    err_d   = err_q;
    if (rx_valid) begin
      word_d = word_full[23:0];
      nb_d   = nb_q + 2'd1;
    end
    case (state_q)
      L_HDR: begin
        if (word_ready) begin
          if (hdr_bad(word_full, 32'(MAX_WORDS))) begin
            err_d   = 1'b1;
            state_d = L_ERR;
          end else begin
            n_d     = word_full[12:0];
            state_d = L_LOAD;
          end
        end
      end
      L_LOAD: begin
        // Bytes arrive many cycles apart, so a new word never meets the count update.
        if (we_q) begin
          cnt_d = cnt_q + 13'd1;
          if (cnt_q + 13'd1 == n_q) begin
            done_d  = 1'b1;
            state_d = L_DONE;
          end
        end else if (word_ready) begin
          we_d   = 1'b1;
          addr_d = cnt_q[11:0];
          din_d  = word_full;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= L_HDR;
      word_q  <= 24'd0;
      nb_q    <= 2'd0;
      n_q     <= 13'd0;
      cnt_q   <= 13'd0;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      din_q   <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      nb_q    <= nb_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_m_progloader.sv
// Self-checking bench for m_progloader: drives 8N1 bytes at 4 clocks per bit
// and compares the memory writes against a byte-stream model of the protocol.
module tb_m_progloader;

  localparam int CPB = 4;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        w_rxd;
  logic        r_done;
  logic        r_err;
  logic        r_ferr;
  logic [12:0] r_cnt;

  m_progloader_if mem_if ();

  m_progloader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(4096)) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_rxd  (w_rxd),
    .mem    (mem_if.master),
    .r_done (r_done),
    .r_err  (r_err),
    .r_ferr (r_ferr),
    .r_cnt  (r_cnt)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] din;
  } wr_t;

  int n_total = 0;
  int n_pass  = 0;

  wr_t         exp_q[$];
  logic [31:0] mdl_word;
  int          mdl_nb;
  int          mdl_phase;
  int          mdl_n;
  int          mdl_cnt;
  bit          mdl_done;
  bit          mdl_err;
  bit          mdl_ferr;

  int          wr_seen;
  logic [31:0] wr_log [16];
  logic        prev_we;
  logic        prev_done;
  logic [11:0] hold_addr;
  logic [31:0] hold_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_word  = 32'd0;
    mdl_nb    = 0;
    mdl_phase = 0;
    mdl_n     = 0;
    mdl_cnt   = 0;
    mdl_done  = 0;
    mdl_err   = 0;
    mdl_ferr  = 0;
  endtask

  // Protocol view: every fourth good byte completes a word; first word is the count.
  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    mdl_word = {mdl_word[23:0], b};
    mdl_nb++;
    if (mdl_nb == 4) begin
      mdl_nb = 0;
      if (mdl_phase == 0) begin
        if (mdl_word == 0 || mdl_word > 4096) begin
          mdl_err   = 1;
          mdl_phase = 2;
        end else begin
          mdl_n     = int'(mdl_word);
          mdl_phase = 1;
        end
      end else if (mdl_phase == 1) begin
        w.addr = 12'(mdl_cnt);
        w.din  = mdl_word;
        exp_q.push_back(w);
        mdl_cnt++;
        if (mdl_cnt == mdl_n) begin
          mdl_done  = 1;
          mdl_phase = 2;
        end
      end
    end
  endtask

  always @(negedge w_clk) begin
    wr_t e;
    if (w_rst) begin
      wr_seen   = 0;
      prev_we   = 1'b0;
      prev_done = 1'b0;
      hold_addr = 12'd0;
      hold_din  = 32'd0;
    end else begin
      chk("cnt_track", {19'd0, r_cnt}, wr_seen);
      if (mem_if.we) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("[TB] FAIL unexpected_we: got we=1 addr=%h din=%h expected we=0", mem_if.addr, mem_if.din);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {20'd0, mem_if.addr}, {20'd0, e.addr});
          chk("wr_din", mem_if.din, e.din);
        end
        wr_log[wr_seen % 16] = mem_if.din;
        hold_addr = mem_if.addr;
        hold_din  = mem_if.din;
        wr_seen++;
      end else begin
        chk("hold_addr", {20'd0, mem_if.addr}, {20'd0, hold_addr});
        chk("hold_din", mem_if.din, hold_din);
      end
      if (r_done && !prev_done) begin
        chk("done_after_last_we", {31'd0, prev_we}, 32'd1);
        chk("done_expected", {31'd0, mdl_done}, 32'd1);
      end
      if (prev_done) chk("done_sticky", {31'd0, r_done}, 32'd1);
      prev_we   = mem_if.we;
      prev_done = r_done;
    end
  end

  task automatic idle(input int n);
    w_rxd = 1'b1;
    repeat (n) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (CPB) @(negedge w_clk);
    end
    if (stop_ok) model_byte(b);
    else mdl_ferr = 1;
    w_rxd = stop_ok;
    repeat (CPB) @(negedge w_clk);
    idle(CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic apply_reset();
    w_rst = 1'b1;
    w_rxd = 1'b1;
    model_clear();
    repeat (3) @(negedge w_clk);
    w_rst = 1'b0;
    idle(4);
  endtask

  task automatic check_output(input string tag);
    idle(12);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    chk({tag, "_done"}, {31'd0, r_done}, {31'd0, mdl_done});
    chk({tag, "_err"}, {31'd0, r_err}, {31'd0, mdl_err});
    chk({tag, "_ferr"}, {31'd0, r_ferr}, {31'd0, mdl_ferr});
    chk({tag, "_cnt"}, {19'd0, r_cnt}, mdl_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, mem_if.we}, 32'd0);
    chk({tag, "_addr"}, {20'd0, mem_if.addr}, 32'd0);
    chk({tag, "_din"}, mem_if.din, 32'd0);
    chk({tag, "_done"}, {31'd0, r_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, r_err}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, r_ferr}, 32'd0);
    chk({tag, "_cnt"}, {19'd0, r_cnt}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rw;
    int          nw;
    w_rst = 1'b1;
    w_rxd = 1'b1;
    model_clear();
    repeat (2) @(negedge w_clk);
    check_reset_outputs("reset");
    w_rst = 1'b0;
    idle(4);

    // Normal two-word load.
    send_word(32'd2);
    send_word(32'h2008_1000);
    send_word(32'h2009_0000);
    check_output("normal");
    chk("normal_w0", wr_log[0], 32'h2008_1000);
    chk("normal_w1", wr_log[1], 32'h2009_0000);
    chk("normal_cnt_lit", {19'd0, r_cnt}, 32'd2);
    chk("normal_done_lit", {31'd0, r_done}, 32'd1);

    // Header above the memory depth.
    apply_reset();
    send_word(32'h0000_1001);
    check_output("badhdr");
    chk("badhdr_err_lit", {31'd0, r_err}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    check_output("badhdr_tail");
    chk("badhdr_done_lit", {31'd0, r_done}, 32'd0);

    // Framing error drops one byte but loading continues.
    apply_reset();
    send_word(32'd1);
    send_byte(8'hAA, 1'b0);
    chk("ferr_lit", {31'd0, r_ferr}, 32'd1);
    chk("ferr_no_we_cnt", {19'd0, r_cnt}, 32'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check_output("ferr");
    chk("ferr_w0", wr_log[0], 32'h1122_3344);

    // One-clock glitch on an idle line.
    apply_reset();
    w_rxd = 1'b0;
    @(negedge w_clk);
    idle(12);
    rw = $urandom;
    send_word(32'd1);
    send_word(rw);
    check_output("glitch");
    chk("glitch_w0", wr_log[0], rw);

    // Reset in the middle of the second word.
    apply_reset();
    send_word(32'd3);
    send_word($urandom);
    send_byte(8'($urandom), 1'b1);
    chk("midload_cnt_lit", {19'd0, r_cnt}, 32'd1);
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (6) @(negedge w_clk);
    #2 w_rst = 1'b1;
    #1 check_reset_outputs("midload_rst");
    apply_reset();
    rw = $urandom;
    send_word(32'd1);
    send_word(rw);
    check_output("reload");
    chk("reload_w0", wr_log[0], rw);

    // Bytes after completion are ignored.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    check_output("postdone");
    chk("postdone_cnt_lit", {19'd0, r_cnt}, 32'd1);

    // Randomized loads, the last one with a bad header.
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      if (it == 3) begin
        send_word(($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(4097, 200000)));
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      end else begin
        nw = $urandom_range(1, 4);
        send_word(32'(nw));
        for (int i = 0; i < nw; i++) begin
          idle($urandom_range(0, 6));
          send_word($urandom);
        end
      end
      check_output("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
